// File: rtl/mem_byte_responder_pkg.sv
// Shared constants and I/O decode helper for the byte-wide memory responder.
package mem_byte_responder_pkg;

    localparam int unsigned IO_DEC_W = 18;
    localparam logic [1:0]  IO_SEL   = 2'b11;
    localparam logic [31:0] IO_BASE  = 32'h0003_0000;
    localparam logic [1:0]  IO_UART  = 2'b00;
    localparam logic [31:0] IO_END   = 32'h0003_0004;

    localparam logic [31:0] IO_UART_ADDR = IO_BASE + {30'b0, IO_UART};

    typedef enum logic [1:0] {
        IO_PORT_UART,
        IO_PORT_END,
        IO_PORT_NONE
    } io_port_e;

    // Only the low IO_DEC_W address bits take part; higher bits alias.
    function automatic io_port_e io_decode(input logic [IO_DEC_W-1:0] addr);
        if (addr == IO_UART_ADDR[IO_DEC_W-1:0])
            return IO_PORT_UART;
        else if (addr == IO_END[IO_DEC_W-1:0])
            return IO_PORT_END;
        else
            return IO_PORT_NONE;
    endfunction

endpackage

// File: rtl/mem_byte_responder_byte_fifo.sv
// Byte FIFO feeding the UART transmitter; push while full succeeds only alongside a pop.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

endmodule

// File: rtl/mem_byte_responder.sv
// Byte RAM plus I/O window (UART TX FIFO, RX byte, program-end) on the CPU memory port.
module mem_byte_responder
    import mem_byte_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    input  logic        is_write,
    output logic [7:0]  mem_rdata,
    output logic        io_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        prog_end,
    output logic [7:0]  prog_end_code,
    output logic        tx_overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  is_io;
    io_port_e              io_port;
    logic                  ram_we;
    logic                  uart_wr;
    logic                  uart_rd;
    logic                  end_wr;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         fifo_count_next;
    logic                  rx_avail;
    logic [7:0]            rx_byte;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^mem_addr[31:IO_DEC_W];

    assign ram_idx = mem_addr[ADDR_WIDTH-1:0];
    assign is_io   = (mem_addr[17:16] == IO_SEL);
    assign io_port = io_decode(mem_addr[IO_DEC_W-1:0]);

    assign ram_we  = rdy && is_write && !is_io;
    assign uart_wr = rdy && is_write && is_io && (io_port == IO_PORT_UART);
    assign end_wr  = rdy && is_write && is_io && (io_port == IO_PORT_END);
    assign uart_rd = rdy && !is_write && is_io && (io_port == IO_PORT_UART);

    assign tx_valid = !fifo_empty;
    assign pop      = rdy && tx_valid && tx_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (uart_wr),
        .pop        (pop),
        .wdata      (mem_wdata),
        .head       (tx_data),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_idx] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata     <= '0;
            io_full       <= 1'b0;
            prog_end      <= 1'b0;
            prog_end_code <= '0;
            tx_overflow   <= 1'b0;
            rx_avail      <= 1'b0;
            rx_byte       <= '0;
        end else if (rdy) begin
            prog_end <= end_wr;
            if (end_wr)
                prog_end_code <= mem_wdata;

            if (uart_wr && fifo_full && !pop)
                tx_overflow <= 1'b1;

            // Registered from count_next so the controller sees it one cycle earlier.
            io_full <= ((CW'(FIFO_DEPTH) - fifo_count_next) <= CW'(FULL_MARGIN));

            if (!is_io)
                mem_rdata <= is_write ? mem_wdata : ram[ram_idx];
            else if (uart_rd)
                mem_rdata <= rx_avail ? rx_byte : 8'h00;
            else
                mem_rdata <= '0;

            if (uart_rd)
                rx_avail <= 1'b0;
            if (rx_valid) begin
                rx_avail <= 1'b1;
                rx_byte  <= rx_data;
            end
        end else begin
            prog_end <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_byte_responder.sv
// Directed bench for mem_byte_responder: vector table plus FIFO, rdy and reset sequences.
module tb_mem_byte_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [7:0]  mem_wdata = '0;
    logic        is_write = 1'b0;
    logic [7:0]  mem_rdata;
    logic        io_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        prog_end;
    logic [7:0]  prog_end_code;
    logic        tx_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_byte_responder #(
        .ADDR_WIDTH  (17),
        .FIFO_DEPTH  (8),
        .FULL_MARGIN (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .is_write      (is_write),
        .mem_rdata     (mem_rdata),
        .io_full       (io_full),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .prog_end      (prog_end),
        .prog_end_code (prog_end_code),
        .tx_overflow   (tx_overflow)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        rxv;
        logic [7:0]  rxd;
        logic [7:0]  e_rdata;
        logic        e_pend;
        logic [7:0]  e_code;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic w);
        mem_addr  = a;
        mem_wdata = d;
        is_write  = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            addr          wdata  we    rxv   rxd    rdata  pend  code
        vecs[0]  = '{32'h0000_0010, 8'hA5, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00};
        vecs[1]  = '{32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00};
        vecs[2]  = '{32'h0000_0020, 8'h3C, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, 8'h00};
        vecs[3]  = '{32'h0002_0020, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 8'h00};
        vecs[4]  = '{32'h0002_0011, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h00};
        vecs[5]  = '{32'h0000_0011, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h00};
        vecs[6]  = '{32'h0003_0008, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[7]  = '{32'h0003_0008, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[8]  = '{32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[9]  = '{32'h0000_0020, 8'h00, 1'b0, 1'b1, 8'h41, 8'h3C, 1'b0, 8'h00};
        vecs[10] = '{32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h41, 1'b0, 8'h00};
        vecs[11] = '{32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[12] = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 8'h42, 8'hA5, 1'b0, 8'h00};
        vecs[13] = '{32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h55, 8'h42, 1'b0, 8'h00};
        vecs[14] = '{32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h55, 1'b0, 8'h00};
        vecs[15] = '{32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h66, 8'h00, 1'b0, 8'h00};
        vecs[16] = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 8'h77, 8'hA5, 1'b0, 8'h00};
        vecs[17] = '{32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h77, 1'b0, 8'h00};
        vecs[18] = '{32'h0003_0004, 8'h07, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h07};
        vecs[19] = '{32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h07};
        vecs[20] = '{32'hFFF3_0004, 8'h99, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h99};
        vecs[21] = '{32'h0000_0020, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 8'h99};

        // Reset state, observed while rst is still held.
        #1;
        chk8("reset mem_rdata", mem_rdata, 8'h00);
        chk1("reset tx_valid", tx_valid, 1'b0);
        chk1("reset io_full", io_full, 1'b0);
        chk1("reset prog_end", prog_end, 1'b0);
        chk8("reset prog_end_code", prog_end_code, 8'h00);
        chk1("reset tx_overflow", tx_overflow, 1'b0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we);
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            tick();
            chk8($sformatf("vec%0d mem_rdata", i), mem_rdata, vecs[i].e_rdata);
            chk1($sformatf("vec%0d prog_end", i), prog_end, vecs[i].e_pend);
            chk8($sformatf("vec%0d prog_end_code", i), prog_end_code, vecs[i].e_code);
            chk1($sformatf("vec%0d tx_valid", i), tx_valid, 1'b0);
            chk1($sformatf("vec%0d io_full", i), io_full, 1'b0);
        end
        rx_valid = 1'b0;

        // rdy=0: everything holds, prog_end stays low, rx pulse ignored.
        rdy = 1'b0;
        drive(32'h0003_0004, 8'h11, 1'b1);
        tick();
        chk1("stall prog_end", prog_end, 1'b0);
        chk8("stall prog_end_code", prog_end_code, 8'h99);
        chk8("stall mem_rdata hold", mem_rdata, 8'h3C);
        drive(32'h0000_0010, 8'hEE, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'h88;
        tick();
        chk8("stall ram write mem_rdata", mem_rdata, 8'h3C);
        rx_valid = 1'b0;
        rdy = 1'b1;
        drive(32'h0000_0010, 8'h00, 1'b0);
        tick();
        chk8("stall ram not written", mem_rdata, 8'hA5);
        drive(32'h0003_0000, 8'h00, 1'b0);
        tick();
        chk8("stall rx ignored", mem_rdata, 8'h00);

        // Fill FIFO with tx_ready=0.
        tx_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            drive(32'h0003_0000, 8'(8'h10 + k), 1'b1);
            tick();
            chk1($sformatf("fill%0d io_full", k), io_full, (k >= 6));
            chk1($sformatf("fill%0d tx_valid", k), tx_valid, 1'b1);
            chk8($sformatf("fill%0d tx_data", k), tx_data, 8'h11);
            chk1($sformatf("fill%0d tx_overflow", k), tx_overflow, 1'b0);
        end

        // Full: push with simultaneous pop succeeds.
        tx_ready = 1'b1;
        drive(32'h0003_0000, 8'h19, 1'b1);
        tick();
        chk8("full push+pop tx_data", tx_data, 8'h12);
        chk1("full push+pop io_full", io_full, 1'b1);
        chk1("full push+pop tx_overflow", tx_overflow, 1'b0);

        // Full with no pop: byte dropped, sticky overflow.
        tx_ready = 1'b0;
        drive(32'h0003_0000, 8'h1A, 1'b1);
        tick();
        chk1("overflow set", tx_overflow, 1'b1);
        chk8("overflow head", tx_data, 8'h12);

        // Drain: expect 0x12..0x19 in order.
        tx_ready = 1'b1;
        drive(32'h0000_0010, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk1($sformatf("drain%0d tx_valid", i), tx_valid, 1'b1);
            chk8($sformatf("drain%0d tx_data", i), tx_data, 8'(8'h12 + i));
            tick();
            chk1($sformatf("drain%0d io_full", i), io_full, (i <= 1));
        end
        chk1("drain empty", tx_valid, 1'b0);
        chk1("overflow sticky", tx_overflow, 1'b1);

        // Reset mid-drain.
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(32'h0003_0000, 8'(8'h21 + k), 1'b1);
            tick();
        end
        tx_ready = 1'b1;
        drive(32'h0000_0010, 8'h00, 1'b0);
        tick();
        chk8("pre-reset tx_data", tx_data, 8'h22);
        chk8("pre-reset mem_rdata", mem_rdata, 8'hA5);
        #2;
        rst = 1'b1;
        #1;
        chk1("async reset tx_valid", tx_valid, 1'b0);
        chk1("async reset tx_overflow", tx_overflow, 1'b0);
        chk8("async reset mem_rdata", mem_rdata, 8'h00);
        chk1("async reset io_full", io_full, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk8("ram survives reset", mem_rdata, 8'hA5);
        chk1("fifo empty after reset", tx_valid, 1'b0);
        drive(32'h0003_0000, 8'h00, 1'b0);
        tick();
        chk8("rx cleared by reset", mem_rdata, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
